// File: rtl/sisc_pkg.sv
// sisc_pkg: opcodes, ALU function codes, FSM states and STAT flag bit positions
package sisc_pkg;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [3:0] FN_ADD = 4'h1;
    localparam logic [3:0] FN_SUB = 4'h2;
    localparam logic [3:0] FN_CMP = 4'h3;
    localparam logic [3:0] FN_NOT = 4'h4;
    localparam logic [3:0] FN_OR  = 4'h5;
    localparam logic [3:0] FN_AND = 4'h6;
    localparam logic [3:0] FN_XOR = 4'h7;
    localparam logic [3:0] FN_ROR = 4'h8;
    localparam logic [3:0] FN_ROL = 4'h9;
    localparam logic [3:0] FN_SHR = 4'hA;
    localparam logic [3:0] FN_SHL = 4'hB;
    localparam int F_Z = 0;
    localparam int F_N = 1;
    localparam int F_C = 2;
    localparam int F_V = 3;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;
endpackage

// File: rtl/sisc_alu.sv
// sisc_alu: combinational ALU producing result, {V,C,N,Z} and write/flag-update enables
module sisc_alu
    import sisc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  fn,
    output logic [31:0] y,
    output logic [3:0]  flags,
    output logic        wr,
    output logic        upd
);
    logic [32:0] sum, dif, shr, shl;
    logic [63:0] rr, rl;
    logic [4:0]  n;
    logic        c, v;
    assign n = b[4:0];
    // Shifts/rotates go through double-width vectors so the bit moved out lands in a fixed spot
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} - {1'b0, b};
        shr = {a, 1'b0} >> n;
        shl = {1'b0, a} << n;
        rr  = {a, a} >> n;
        rl  = {a, a} << n;
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (fn)
            FN_ADD: begin
                y = sum[31:0];
                c = sum[32];
                v = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            FN_SUB, FN_CMP: begin
                y = dif[31:0];
                c = dif[32];
                v = (a[31] != b[31]) && (dif[31] != a[31]);
            end
            FN_NOT: y = ~a;
            FN_OR:  y = a | b;
            FN_AND: y = a & b;
            FN_XOR: y = a ^ b;
            FN_ROR: begin
                y = rr[31:0];
                c = (|n) & rr[31];
            end
            FN_ROL: begin
                y = rl[63:32];
                c = (|n) & rl[32];
            end
            FN_SHR: begin
                y = shr[32:1];
                c = shr[0];
            end
            FN_SHL: begin
                y = shl[31:0];
                c = shl[32];
            end
            default: y = '0;
        endcase
        upd = fn inside {[FN_ADD:FN_SHL]};
        wr  = upd && fn != FN_CMP;
        flags = '0;
        flags[F_Z] = y == 32'd0;
        flags[F_N] = y[31];
        flags[F_C] = c;
        flags[F_V] = v;
    end
endmodule

// File: rtl/sisc_cpu.sv
// sisc_cpu: 5-cycle multicycle SISC core with 16x32 register file; SISC_TRACE_EN adds a writeback trace
module sisc_cpu
    import sisc_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_F,
    input  logic [31:0] IR,
    output logic        HALT,
    output logic [3:0]  STAT
);
    state_t      state;
    logic [31:0] ir_q;
    logic [31:0] rf [16];
    logic [3:0]  op, rs, rt, rd, fn, dst, flags;
    logic [31:0] a, b, y;
    logic        imm_mode, wr, upd, unused_mm;
    assign unused_mm = ^ir_q[26:24];
    // Decode operands from the latched instruction; immediate form is an add into rt
    always_comb begin
        op       = ir_q[31:28];
        imm_mode = ir_q[27];
        rs       = ir_q[23:20];
        rt       = ir_q[19:16];
        rd       = ir_q[15:12];
        a        = rs == 4'd0 ? 32'd0 : rf[rs];
        b        = imm_mode ? {16'd0, ir_q[15:0]} : (rt == 4'd0 ? 32'd0 : rf[rt]);
        fn       = imm_mode ? FN_ADD : ir_q[3:0];
        dst      = imm_mode ? rt : rd;
    end
    sisc_alu u_alu (.a(a), .b(b), .fn(fn), .y(y), .flags(flags), .wr(wr), .upd(upd));
    // Instruction sequencer; register file and flags only change in writeback
    always_ff @(posedge CLK or posedge RST_F) begin
        if (RST_F) begin
            state <= S_FETCH;
            ir_q  <= '0;
            HALT  <= 1'b0;
            STAT  <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir_q  <= IR;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    state <= op == OP_HLT ? S_HALT : S_EXECUTE;
                    HALT  <= op == OP_HLT;
                end
                S_EXECUTE: state <= S_MEM;
                S_MEM:     state <= S_WB;
                S_WB: begin
                    if (op == OP_ALU && wr && dst != 4'd0) rf[dst] <= y;
                    if (op == OP_ALU && upd) STAT <= flags;
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end
`ifdef SISC_TRACE_EN
    // Simulation-only log of each writeback
    always_ff @(posedge CLK) begin
        if (!RST_F && state == S_WB && op == OP_ALU && wr)
            $display("%0t ir=%h r%0d=%h", $time, ir_q, dst, y);
    end
`endif
endmodule

// File: tb/tb_sisc_cpu.sv
// tb_sisc_cpu: table-driven scoreboard bench for sisc_cpu
module tb_sisc_cpu;
    logic        CLK = 1'b0;
    logic        RST_F = 1'b1;
    logic [31:0] IR = '0;
    logic        HALT;
    logic [3:0]  STAT;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] ir;
        int          idx;
        logic [31:0] val;
        logic [3:0]  st;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 CLK = ~CLK;

    sisc_cpu dut (.CLK(CLK), .RST_F(RST_F), .IR(IR), .HALT(HALT), .STAT(STAT));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] ir);
        IR = ir;
        repeat (5) @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t e;
        vecs.push_back('{32'h00000000, 1, 32'h00000000, 4'h0});
        vecs.push_back('{32'h8802000A, 2, 32'h0000000A, 4'h0});
        vecs.push_back('{32'h88030007, 3, 32'h00000007, 4'h0});
        vecs.push_back('{32'h80231002, 1, 32'h00000003, 4'h0});
        vecs.push_back('{32'h80101004, 1, 32'hFFFFFFFC, 4'h2});
        vecs.push_back('{32'h80231005, 1, 32'h0000000F, 4'h0});
        vecs.push_back('{32'h80231006, 1, 32'h00000002, 4'h0});
        vecs.push_back('{32'h80231007, 1, 32'h0000000D, 4'h0});
        vecs.push_back('{32'h80321003, 1, 32'h0000000D, 4'h6});
        vecs.push_back('{32'h5FFFFFFF, 1, 32'h0000000D, 4'h6});
        vecs.push_back('{32'h88020001, 2, 32'h00000001, 4'h0});
        vecs.push_back('{32'h80321008, 1, 32'h80000003, 4'h6});
        vecs.push_back('{32'h80321009, 1, 32'h0000000E, 4'h0});
        vecs.push_back('{32'h8032100A, 1, 32'h00000003, 4'h4});
        vecs.push_back('{32'h80321000, 1, 32'h00000003, 4'h4});
        vecs.push_back('{32'h8032100B, 1, 32'h0000000E, 4'h0});
        vecs.push_back('{32'h80221002, 1, 32'h00000000, 4'h1});
        vecs.push_back('{32'h80001004, 1, 32'hFFFFFFFF, 4'h2});
        vecs.push_back('{32'h80121001, 1, 32'h00000000, 4'h5});
        vecs.push_back('{32'h80001004, 1, 32'hFFFFFFFF, 4'h2});
        vecs.push_back('{32'h8012100A, 1, 32'h7FFFFFFF, 4'h4});
        vecs.push_back('{32'h80121001, 1, 32'h80000000, 4'hA});
        vecs.push_back('{32'h88000005, 0, 32'h00000000, 4'h0});
        vecs.push_back('{32'h8803FFFF, 3, 32'h0000FFFF, 4'h0});
        vecs.push_back('{32'h88040021, 4, 32'h00000021, 4'h0});
        vecs.push_back('{32'h80245008, 5, 32'h80000000, 4'h6});

        repeat (2) @(posedge CLK);
        #1;
        chk("reset halt", HALT, 0);
        chk("reset stat", STAT, 0);
        RST_F = 1'b0;

        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i]);
            run(vecs[i].ir);
            e = exp_q.pop_front();
            chk($sformatf("v%0d r%0d", i, e.idx), dut.rf[e.idx], e.val);
            chk($sformatf("v%0d stat", i), STAT, e.st);
            chk($sformatf("v%0d halt", i), HALT, 0);
        end

        IR = 32'h88020064;
        @(posedge CLK);
        #1 IR = 32'h8806FFFF;
        repeat (4) @(posedge CLK);
        #1 IR = 32'h0;
        chk("midir r2", dut.rf[2], 32'h64);
        chk("midir r6", dut.rf[6], 32'h0);

        IR = 32'h88070009;
        repeat (3) @(posedge CLK);
        #2 RST_F = 1'b1;
        #1;
        chk("abort r7", dut.rf[7], 32'h0);
        chk("abort r2", dut.rf[2], 32'h0);
        chk("abort stat", STAT, 0);
        IR = 32'h0;
        @(negedge CLK) RST_F = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("abort r7 later", dut.rf[7], 32'h0);

        run(32'h80001004);
        chk("pre-halt r1", dut.rf[1], 32'hFFFFFFFF);
        chk("pre-halt stat", STAT, 4'h2);
        IR = 32'hF0000000;
        repeat (2) @(posedge CLK);
        #1;
        chk("halt set", HALT, 1);
        IR = 32'h88011234;
        repeat (10) @(posedge CLK);
        #1;
        chk("halt held", HALT, 1);
        chk("halt r1", dut.rf[1], 32'hFFFFFFFF);
        chk("halt stat", STAT, 4'h2);

        #2 RST_F = 1'b1;
        #1;
        chk("rst halt", HALT, 0);
        chk("rst stat", STAT, 0);
        for (int r = 1; r < 16; r++) chk($sformatf("rst r%0d", r), dut.rf[r], 32'h0);
        IR = 32'h0;
        @(negedge CLK) RST_F = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("post-rst halt", HALT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
